// File: rtl/pipeline_pkg.sv
// Shared types for the execute stage: ALU operation encoding, memory-stage opcodes
// and the execute FSM state encoding.
package pipeline_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_MUL   = 4'd11,
        ALU_DIVU  = 4'd12,
        ALU_REMU  = 4'd13
    } alu_op_e;

    localparam logic [6:0] OP_NONE  = 7'd0;
    localparam logic [6:0] OP_LOAD  = 7'd1;
    localparam logic [6:0] OP_STORE = 7'd2;
    localparam logic [6:0] OP_REG   = 7'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DIV_BUSY = 2'd2,
        ST_HOLD     = 2'd3
    } exec_state_e;

endpackage

// File: rtl/execute_muldiv.sv
// Iterative shift-add multiplier / restoring unsigned divider, one bit per clock.
// Only built when EXECUTE_MULDIV_EN is defined.
`ifdef EXECUTE_MULDIV_EN
module execute_muldiv
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  alu_op_e               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    // MUL: acc = partial product, x = shifted multiplicand, y = shifted multiplier.
    // DIV: acc = partial remainder, x = dividend shifting out / quotient shifting in, y = divisor.
    logic                  active;
    logic [CW-1:0]         count;
    alu_op_e               op_q;
    logic [DATA_WIDTH-1:0] acc, x, y;
    logic [DATA_WIDTH-1:0] acc_n, x_n;
    logic [DATA_WIDTH:0]   shifted;

    always_comb begin
        shifted = {acc, x[DATA_WIDTH-1]};
        acc_n   = acc;
        x_n     = x;
        if (op_q == ALU_MUL) begin
            acc_n = acc + (y[0] ? x : '0);
            x_n   = x << 1;
        end else if (shifted >= {1'b0, y}) begin
            acc_n = shifted[DATA_WIDTH-1:0] - y;
            x_n   = {x[DATA_WIDTH-2:0], 1'b1};
        end else begin
            acc_n = shifted[DATA_WIDTH-1:0];
            x_n   = {x[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // The final step's value is presented combinationally so the caller can capture it on the same edge.
    assign done   = active && (count == LAST);
    assign result = (op_q == ALU_DIVU) ? x_n : acc_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            count  <= '0;
            op_q   <= ALU_MUL;
            acc    <= '0;
            x      <= '0;
            y      <= '0;
        end else if (start) begin
            active <= 1'b1;
            count  <= '0;
            op_q   <= op;
            acc    <= '0;
            x      <= a;
            y      <= b;
        end else if (active) begin
            acc   <= acc_n;
            x     <= x_n;
            count <= count + CW'(1);
            if (op_q == ALU_MUL) y <= y >> 1;
            if (done) active <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/pipeline_execute.sv
// Execute stage: ALU / address generation into a mem_ready-gated output register.
// Iterative MUL/DIVU/REMU are built only when EXECUTE_MULDIV_EN is defined.
module pipeline_execute
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]   r1_val,
    input  logic [DATA_WIDTH-1:0]   r2_val,
    input  logic [DATA_WIDTH-1:0]   imm,
    input  logic                    use_imm,
    input  logic [4:0]              dst_reg,
    input  logic [6:0]              mem_opcode,
    input  logic [3:0]              mem_size,
    input  logic                    ecall,
    input  logic                    mem_ready,
    output logic [DATA_WIDTH-1:0]   ex_res,
    output logic [DATA_WIDTH-1:0]   ex_r2_val,
    output logic [4:0]              ex_dst_reg,
    output logic [6:0]              ex_opcode,
    output logic [3:0]              ex_mem_size,
    output logic                    ex_ecall,
    output logic                    busy,
    output logic [1:0]              state_dbg
);
    localparam int SHW = $clog2(DATA_WIDTH);

    // Handshake: an instruction transfers in on a clock edge where in_valid && in_ready.
    // Downstream, ex_opcode != 0 marks a valid slot; the output register only changes when mem_ready is high.
    exec_state_e           state;
    logic [DATA_WIDTH-1:0] op_b, alu_res;
    logic                  accept;

    function automatic logic [DATA_WIDTH-1:0] alu_eval(
        input logic [ALU_OP_WIDTH-1:0] op,
        input logic [DATA_WIDTH-1:0]   a,
        input logic [DATA_WIDTH-1:0]   b
    );
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            ALU_ADD:   alu_eval = a + b;
            ALU_SUB:   alu_eval = a - b;
            ALU_AND:   alu_eval = a & b;
            ALU_OR:    alu_eval = a | b;
            ALU_XOR:   alu_eval = a ^ b;
            ALU_SLL:   alu_eval = a << sh;
            ALU_SRL:   alu_eval = a >> sh;
            ALU_SRA:   alu_eval = $signed(a) >>> sh;
            ALU_SLT:   alu_eval = DATA_WIDTH'($signed(a) < $signed(b));
            ALU_SLTU:  alu_eval = DATA_WIDTH'(a < b);
            ALU_PASSB: alu_eval = b;
            default:   alu_eval = '0;
        endcase
    endfunction

    assign op_b      = use_imm ? imm : r2_val;
    assign alu_res   = alu_eval(alu_op, r1_val, op_b);
    assign in_ready  = reset && (state == ST_IDLE) && mem_ready;
    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

`ifdef EXECUTE_MULDIV_EN
    logic                  is_md, md_done;
    logic [DATA_WIDTH-1:0] md_result, hold_res, lat_r2;
    logic [4:0]            lat_dst;
    logic [6:0]            lat_opcode;
    logic [3:0]            lat_size;
    logic                  lat_ecall;

    assign is_md = (alu_op == ALU_MUL) || (alu_op == ALU_DIVU) || (alu_op == ALU_REMU);
    assign busy  = (state != ST_IDLE);

    execute_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && is_md),
        .op     (alu_op_e'(alu_op)),
        .a      (r1_val),
        .b      (op_b),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ex_res      <= '0;
            ex_r2_val   <= '0;
            ex_dst_reg  <= '0;
            ex_opcode   <= OP_NONE;
            ex_mem_size <= '0;
            ex_ecall    <= 1'b0;
`ifdef EXECUTE_MULDIV_EN
            hold_res    <= '0;
            lat_r2      <= '0;
            lat_dst     <= '0;
            lat_opcode  <= OP_NONE;
            lat_size    <= '0;
            lat_ecall   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef EXECUTE_MULDIV_EN
                        if (is_md) begin
                            state      <= (alu_op == ALU_MUL) ? ST_MUL_BUSY : ST_DIV_BUSY;
                            lat_r2     <= r2_val;
                            lat_dst    <= dst_reg;
                            lat_opcode <= mem_opcode;
                            lat_size   <= mem_size;
                            lat_ecall  <= ecall;
                            ex_opcode  <= OP_NONE;
                        end else
`endif
                        begin
                            ex_res      <= alu_res;
                            ex_r2_val   <= r2_val;
                            ex_dst_reg  <= dst_reg;
                            ex_opcode   <= mem_opcode;
                            ex_mem_size <= mem_size;
                            ex_ecall    <= ecall;
                        end
                    end else if (mem_ready) begin
                        ex_opcode <= OP_NONE;
                    end
                end
`ifdef EXECUTE_MULDIV_EN
                ST_MUL_BUSY, ST_DIV_BUSY: begin
                    // Iteration never stalls; only the final hand-off waits on mem_ready.
                    if (md_done) begin
                        if (mem_ready) begin
                            ex_res      <= md_result;
                            ex_r2_val   <= lat_r2;
                            ex_dst_reg  <= lat_dst;
                            ex_opcode   <= lat_opcode;
                            ex_mem_size <= lat_size;
                            ex_ecall    <= lat_ecall;
                            state       <= ST_IDLE;
                        end else begin
                            hold_res <= md_result;
                            state    <= ST_HOLD;
                        end
                    end else if (mem_ready) begin
                        ex_opcode <= OP_NONE;
                    end
                end
                ST_HOLD: begin
                    if (mem_ready) begin
                        ex_res      <= hold_res;
                        ex_r2_val   <= lat_r2;
                        ex_dst_reg  <= lat_dst;
                        ex_opcode   <= lat_opcode;
                        ex_mem_size <= lat_size;
                        ex_ecall    <= lat_ecall;
                        state       <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
